// File: rtl/ins_stream_encoder.sv
// RISC-V instruction stream encoder: packs field bundles into 32-bit words and writes them
// to consecutive instruction-memory words. Define ENC_OPCODE_CHECK_EN to also reject bad fmt/opcode pairs.
module ins_stream_encoder #(
  parameter logic [31:0] BASE_ADDR   = 32'h28,
  parameter int          DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  input  logic        last,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic [15:0] count,
  output logic        err,
  output logic        full,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, WR, DONE} state_t;

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_SB = 3'd3;
  localparam logic [2:0] FMT_UJ = 3'd4;
  localparam logic [2:0] FMT_U  = 3'd5;

  localparam logic [15:0] DEPTH_CNT = 16'(DEPTH_WORDS);

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        in_ready_d, mem_we_d, err_d, full_d, done_d;
  logic [31:0] addr_d, wdata_d;
  logic [15:0] count_d, count_inc;
  logic [31:0] enc_word;
  logic        imm_ok, op_ok, bundle_ok;

  // Range checks reduce to "upper bits are a pure sign extension" of the field width.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    enc_word = '0;
    imm_ok   = 1'b0;
    case (fmt)
      FMT_R: begin
        imm_ok   = 1'b1;
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      FMT_I: begin
        imm_ok   = (imm[31:11] == {21{imm[31]}});
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: begin
        imm_ok   = (imm[31:11] == {21{imm[31]}});
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      FMT_SB: begin
        imm_ok   = (imm[31:12] == {20{imm[31]}}) && !imm[0];
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      FMT_UJ: begin
        imm_ok   = (imm[31:20] == {12{imm[31]}}) && !imm[0];
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      end
      FMT_U: begin
        imm_ok   = (imm[11:0] == 12'd0);
        enc_word = {imm[31:12], rd, opcode};
      end
      default: begin
        imm_ok   = 1'b0;
        enc_word = '0;
      end
    endcase
  end

`ifdef ENC_OPCODE_CHECK_EN
  always_comb begin
    op_ok = 1'b0;
    case (fmt)
      FMT_R:   op_ok = (opcode == 7'h33);
      FMT_I:   op_ok = (opcode == 7'h03) || (opcode == 7'h13) || (opcode == 7'h67);
      FMT_S:   op_ok = (opcode == 7'h23);
      FMT_SB:  op_ok = (opcode == 7'h63);
      FMT_UJ:  op_ok = (opcode == 7'h6F);
      FMT_U:   op_ok = (opcode == 7'h37) || (opcode == 7'h17);
      default: op_ok = 1'b0;
    endcase
  end
`else
  assign op_ok = 1'b1;
`endif

  assign bundle_ok = imm_ok && op_ok;
  assign count_inc = count + 16'd1;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    mem_we_d = mem_we;
    addr_d   = mem_addr;
    wdata_d  = mem_wdata;
    count_d  = count;
    err_d    = err;
    full_d   = full;
    case (state_q)
      IDLE: begin
        // in_ready is low for the first cycle after reset, so nothing is accepted then.
        if (in_ready && in_valid) begin
          if (bundle_ok) begin
            wdata_d  = enc_word;
            mem_we_d = 1'b1;
            last_d   = last;
            state_d  = WR;
          end else begin
            err_d = 1'b1;
            if (last) state_d = DONE;
          end
        end
      end
      WR: begin
        if (mem_ack) begin
          mem_we_d = 1'b0;
          addr_d   = mem_addr + 32'd4;
          count_d  = count_inc;
          if (count_inc == DEPTH_CNT) full_d = 1'b1;
          state_d = (last_q || (count_inc == DEPTH_CNT)) ? DONE : IDLE;
        end
      end
      default: begin
        mem_we_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments, so every register samples the pre-edge values.
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      count     <= '0;
      err       <= 1'b0;
      full      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      in_ready  <= in_ready_d;
      mem_we    <= mem_we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      count     <= count_d;
      err       <= err_d;
      full      <= full_d;
      done      <= done_d;
    end
  end

endmodule
